// File: rtl/cabac_decode_bin.sv
// CABAC regular-bin decoder: context lookup, MPS/LPS decision and
// renormalization, fully combinational so the parent can update in one clock.
module cabac_decode_bin (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] i_ivlCurrRange,
    input  logic [8:0] i_ivlOffset,
    input  logic [5:0] i_pStateIdx,
    input  logic       i_valMps,
    input  logic [5:0] i_rbsp_in,
    output logic [8:0] o_ivlCurrRange,
    output logic [8:0] o_ivlOffset,
    output logic [5:0] o_pStateIdx,
    output logic       o_valMps,
    output logic       o_binVal,
    output logic [2:0] o_output_len
);

    logic [5:0]  state_eff;
    logic [1:0]  q_range_idx;
    logic [31:0] lps_row;
    logic [7:0]  r_lps;
    logic [8:0]  r_mps;
    logic        is_lps;
    logic [8:0]  range_dec;
    logic [8:0]  off_dec;
    logic [2:0]  shift;
    logic [14:0] off_cat;
    logic [5:0]  trans_lps;
    logic        unused_ok;

    // State 63 is folded onto 62 so renormalization never exceeds six bits.
    assign state_eff   = (i_pStateIdx == 6'd63) ? 6'd62 : i_pStateIdx;
    assign q_range_idx = i_ivlCurrRange[7:6];

    always_comb begin
        lps_row = {8'd6, 8'd8, 8'd9, 8'd11};
        case (state_eff)
            6'd0:  lps_row = {8'd128, 8'd176, 8'd208, 8'd240};
            6'd1:  lps_row = {8'd128, 8'd167, 8'd197, 8'd227};
            6'd2:  lps_row = {8'd128, 8'd158, 8'd187, 8'd216};
            6'd3:  lps_row = {8'd123, 8'd150, 8'd178, 8'd205};
            6'd4:  lps_row = {8'd116, 8'd142, 8'd169, 8'd195};
            6'd5:  lps_row = {8'd111, 8'd135, 8'd160, 8'd185};
            6'd6:  lps_row = {8'd105, 8'd128, 8'd152, 8'd175};
            6'd7:  lps_row = {8'd100, 8'd122, 8'd144, 8'd166};
            6'd8:  lps_row = {8'd95,  8'd116, 8'd137, 8'd158};
            6'd9:  lps_row = {8'd90,  8'd110, 8'd130, 8'd150};
            6'd10: lps_row = {8'd85,  8'd104, 8'd123, 8'd140};
            6'd11: lps_row = {8'd81,  8'd99,  8'd117, 8'd133};
            6'd12: lps_row = {8'd77,  8'd94,  8'd111, 8'd126};
            6'd13: lps_row = {8'd73,  8'd89,  8'd105, 8'd120};
            6'd14: lps_row = {8'd69,  8'd85,  8'd100, 8'd114};
            6'd15: lps_row = {8'd66,  8'd80,  8'd95,  8'd108};
            6'd16: lps_row = {8'd62,  8'd76,  8'd90,  8'd102};
            6'd17: lps_row = {8'd59,  8'd72,  8'd86,  8'd97};
            6'd18: lps_row = {8'd56,  8'd69,  8'd81,  8'd92};
            6'd19: lps_row = {8'd53,  8'd65,  8'd77,  8'd87};
            6'd20: lps_row = {8'd51,  8'd62,  8'd73,  8'd83};
            6'd21: lps_row = {8'd48,  8'd59,  8'd69,  8'd79};
            6'd22: lps_row = {8'd46,  8'd56,  8'd66,  8'd75};
            6'd23: lps_row = {8'd43,  8'd53,  8'd63,  8'd71};
            6'd24: lps_row = {8'd41,  8'd50,  8'd59,  8'd67};
            6'd25: lps_row = {8'd39,  8'd48,  8'd56,  8'd64};
            6'd26: lps_row = {8'd37,  8'd45,  8'd53,  8'd61};
            6'd27: lps_row = {8'd35,  8'd43,  8'd50,  8'd58};
            6'd28: lps_row = {8'd33,  8'd41,  8'd48,  8'd55};
            6'd29: lps_row = {8'd32,  8'd39,  8'd46,  8'd52};
            6'd30: lps_row = {8'd30,  8'd37,  8'd43,  8'd49};
            6'd31: lps_row = {8'd29,  8'd35,  8'd41,  8'd47};
            6'd32: lps_row = {8'd27,  8'd33,  8'd39,  8'd45};
            6'd33: lps_row = {8'd26,  8'd31,  8'd37,  8'd42};
            6'd34: lps_row = {8'd24,  8'd30,  8'd35,  8'd40};
            6'd35: lps_row = {8'd23,  8'd28,  8'd33,  8'd38};
            6'd36: lps_row = {8'd22,  8'd27,  8'd31,  8'd36};
            6'd37: lps_row = {8'd21,  8'd26,  8'd30,  8'd34};
            6'd38: lps_row = {8'd20,  8'd24,  8'd29,  8'd32};
            6'd39: lps_row = {8'd19,  8'd23,  8'd27,  8'd31};
            6'd40: lps_row = {8'd18,  8'd22,  8'd26,  8'd29};
            6'd41: lps_row = {8'd17,  8'd21,  8'd25,  8'd28};
            6'd42: lps_row = {8'd16,  8'd20,  8'd23,  8'd27};
            6'd43: lps_row = {8'd15,  8'd19,  8'd22,  8'd25};
            6'd44: lps_row = {8'd14,  8'd18,  8'd21,  8'd24};
            6'd45: lps_row = {8'd14,  8'd17,  8'd20,  8'd23};
            6'd46: lps_row = {8'd13,  8'd16,  8'd19,  8'd22};
            6'd47: lps_row = {8'd12,  8'd15,  8'd18,  8'd21};
            6'd48: lps_row = {8'd12,  8'd14,  8'd17,  8'd20};
            6'd49: lps_row = {8'd11,  8'd14,  8'd16,  8'd19};
            6'd50: lps_row = {8'd11,  8'd13,  8'd15,  8'd18};
            6'd51: lps_row = {8'd10,  8'd12,  8'd15,  8'd17};
            6'd52: lps_row = {8'd10,  8'd12,  8'd14,  8'd16};
            6'd53: lps_row = {8'd9,   8'd11,  8'd13,  8'd15};
            6'd54: lps_row = {8'd9,   8'd11,  8'd12,  8'd14};
            6'd55: lps_row = {8'd8,   8'd10,  8'd12,  8'd14};
            6'd56: lps_row = {8'd8,   8'd9,   8'd11,  8'd13};
            6'd57: lps_row = {8'd7,   8'd9,   8'd11,  8'd12};
            6'd58: lps_row = {8'd7,   8'd9,   8'd10,  8'd12};
            6'd59: lps_row = {8'd7,   8'd8,   8'd10,  8'd11};
            6'd60: lps_row = {8'd6,   8'd8,   8'd9,   8'd11};
            6'd61: lps_row = {8'd6,   8'd7,   8'd9,   8'd10};
            default: lps_row = {8'd6, 8'd8, 8'd9, 8'd11};
        endcase
    end

    always_comb begin
        trans_lps = 6'd38;
        case (state_eff)
            6'd0:  trans_lps = 6'd0;   6'd1:  trans_lps = 6'd0;
            6'd2:  trans_lps = 6'd1;   6'd3:  trans_lps = 6'd2;
            6'd4:  trans_lps = 6'd2;   6'd5:  trans_lps = 6'd4;
            6'd6:  trans_lps = 6'd4;   6'd7:  trans_lps = 6'd5;
            6'd8:  trans_lps = 6'd6;   6'd9:  trans_lps = 6'd7;
            6'd10: trans_lps = 6'd8;   6'd11: trans_lps = 6'd9;
            6'd12: trans_lps = 6'd9;   6'd13: trans_lps = 6'd11;
            6'd14: trans_lps = 6'd11;  6'd15: trans_lps = 6'd12;
            6'd16: trans_lps = 6'd13;  6'd17: trans_lps = 6'd13;
            6'd18: trans_lps = 6'd15;  6'd19: trans_lps = 6'd15;
            6'd20: trans_lps = 6'd16;  6'd21: trans_lps = 6'd16;
            6'd22: trans_lps = 6'd18;  6'd23: trans_lps = 6'd18;
            6'd24: trans_lps = 6'd19;  6'd25: trans_lps = 6'd19;
            6'd26: trans_lps = 6'd21;  6'd27: trans_lps = 6'd21;
            6'd28: trans_lps = 6'd22;  6'd29: trans_lps = 6'd22;
            6'd30: trans_lps = 6'd23;  6'd31: trans_lps = 6'd24;
            6'd32: trans_lps = 6'd24;  6'd33: trans_lps = 6'd25;
            6'd34: trans_lps = 6'd26;  6'd35: trans_lps = 6'd26;
            6'd36: trans_lps = 6'd27;  6'd37: trans_lps = 6'd27;
            6'd38: trans_lps = 6'd28;  6'd39: trans_lps = 6'd29;
            6'd40: trans_lps = 6'd29;  6'd41: trans_lps = 6'd30;
            6'd42: trans_lps = 6'd30;  6'd43: trans_lps = 6'd30;
            6'd44: trans_lps = 6'd31;  6'd45: trans_lps = 6'd32;
            6'd46: trans_lps = 6'd32;  6'd47: trans_lps = 6'd33;
            6'd48: trans_lps = 6'd33;  6'd49: trans_lps = 6'd33;
            6'd50: trans_lps = 6'd34;  6'd51: trans_lps = 6'd34;
            6'd52: trans_lps = 6'd35;  6'd53: trans_lps = 6'd35;
            6'd54: trans_lps = 6'd35;  6'd55: trans_lps = 6'd36;
            6'd56: trans_lps = 6'd36;  6'd57: trans_lps = 6'd36;
            6'd58: trans_lps = 6'd37;  6'd59: trans_lps = 6'd37;
            6'd60: trans_lps = 6'd37;  6'd61: trans_lps = 6'd38;
            default: trans_lps = 6'd38;
        endcase
    end

    // ~q selects the row byte for qRangeIdx (column 0 is the top byte).
    assign r_lps     = lps_row[{~q_range_idx, 3'b000} +: 8];
    assign r_mps     = i_ivlCurrRange - {1'b0, r_lps};
    assign is_lps    = (i_ivlOffset >= r_mps);
    assign range_dec = is_lps ? {1'b0, r_lps} : r_mps;
    assign off_dec   = is_lps ? (i_ivlOffset - r_mps) : i_ivlOffset;

    always_comb begin
        if (range_dec[8])      shift = 3'd0;
        else if (range_dec[7]) shift = 3'd1;
        else if (range_dec[6]) shift = 3'd2;
        else if (range_dec[5]) shift = 3'd3;
        else if (range_dec[4]) shift = 3'd4;
        else if (range_dec[3]) shift = 3'd5;
        else                   shift = 3'd6;
    end

    // Appending the bitstream then shifting right pulls in the top n bits.
    assign off_cat = {off_dec, i_rbsp_in} >> (3'd6 - shift);

    assign o_ivlCurrRange = range_dec << shift;
    assign o_ivlOffset    = off_cat[8:0];
    assign o_output_len   = shift;
    assign o_binVal       = i_valMps ^ is_lps;
    assign o_valMps       = i_valMps ^ (is_lps && (state_eff == 6'd0));
    assign o_pStateIdx    = is_lps ? trans_lps :
                            (state_eff == 6'd62) ? 6'd62 :
                            state_eff + 6'd1;

    assign unused_ok = ^{clk, rst, off_cat[14:9]};

endmodule

// File: tb/tb_cabac_decode_bin.sv
// Directed and table-sweep checks for cabac_decode_bin against an
// independent model of the H.265 context tables and renormalization.
module tb_cabac_decode_bin;

    logic       clk;
    logic       rst;
    logic [8:0] i_ivlCurrRange;
    logic [8:0] i_ivlOffset;
    logic [5:0] i_pStateIdx;
    logic       i_valMps;
    logic [5:0] i_rbsp_in;
    logic [8:0] o_ivlCurrRange;
    logic [8:0] o_ivlOffset;
    logic [5:0] o_pStateIdx;
    logic       o_valMps;
    logic       o_binVal;
    logic [2:0] o_output_len;

    int n_checks = 0;
    int n_fail   = 0;

    cabac_decode_bin dut (
        .clk            (clk),
        .rst            (rst),
        .i_ivlCurrRange (i_ivlCurrRange),
        .i_ivlOffset    (i_ivlOffset),
        .i_pStateIdx    (i_pStateIdx),
        .i_valMps       (i_valMps),
        .i_rbsp_in      (i_rbsp_in),
        .o_ivlCurrRange (o_ivlCurrRange),
        .o_ivlOffset    (o_ivlOffset),
        .o_pStateIdx    (o_pStateIdx),
        .o_valMps       (o_valMps),
        .o_binVal       (o_binVal),
        .o_output_len   (o_output_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int lps_tab [64][4] = '{
        '{128,176,208,240}, '{128,167,197,227}, '{128,158,187,216},
        '{123,150,178,205}, '{116,142,169,195}, '{111,135,160,185},
        '{105,128,152,175}, '{100,122,144,166}, '{95,116,137,158},
        '{90,110,130,150},  '{85,104,123,140},  '{81,99,117,133},
        '{77,94,111,126},   '{73,89,105,120},   '{69,85,100,114},
        '{66,80,95,108},    '{62,76,90,102},    '{59,72,86,97},
        '{56,69,81,92},     '{53,65,77,87},     '{51,62,73,83},
        '{48,59,69,79},     '{46,56,66,75},     '{43,53,63,71},
        '{41,50,59,67},     '{39,48,56,64},     '{37,45,53,61},
        '{35,43,50,58},     '{33,41,48,55},     '{32,39,46,52},
        '{30,37,43,49},     '{29,35,41,47},     '{27,33,39,45},
        '{26,31,37,42},     '{24,30,35,40},     '{23,28,33,38},
        '{22,27,31,36},     '{21,26,30,34},     '{20,24,29,32},
        '{19,23,27,31},     '{18,22,26,29},     '{17,21,25,28},
        '{16,20,23,27},     '{15,19,22,25},     '{14,18,21,24},
        '{14,17,20,23},     '{13,16,19,22},     '{12,15,18,21},
        '{12,14,17,20},     '{11,14,16,19},     '{11,13,15,18},
        '{10,12,15,17},     '{10,12,14,16},     '{9,11,13,15},
        '{9,11,12,14},      '{8,10,12,14},      '{8,9,11,13},
        '{7,9,11,12},       '{7,9,10,12},       '{7,8,10,11},
        '{6,8,9,11},        '{6,7,9,10},        '{6,8,9,11},
        '{2,2,2,2}
    };

    int trans_tab [64] = '{
        0,0,1,2,2,4,4,5,6,7,8,9,9,11,11,12,
        13,13,15,15,16,16,18,18,19,19,21,21,22,22,23,24,
        24,25,26,26,27,27,28,29,29,30,30,30,31,32,32,33,
        33,33,34,34,35,35,35,36,36,36,37,37,37,38,38,63
    };

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packed result: {range9, off9, state6, mps1, bin1, len3}
    function automatic logic [28:0] model(input int rng, input int off,
                                          input int st, input int mps,
                                          input logic [5:0] rb);
        int s, q, rl, rm, r, o, ns, nm, b, n;
        s = (st == 63) ? 62 : st;
        q = (rng >> 6) & 3;
        rl = lps_tab[s][q];
        rm = rng - rl;
        if (off < rm) begin
            b = mps; r = rm; o = off; nm = mps;
            ns = (s == 62) ? 62 : s + 1;
        end else begin
            b = 1 - mps; r = rl; o = off - rm;
            ns = trans_tab[s];
            nm = (s == 0) ? 1 - mps : mps;
        end
        n = 0;
        while (r < 256 && n < 6) begin
            r = r * 2;
            o = o * 2 + int'(rb[5 - n]);
            n++;
        end
        model = {r[8:0], o[8:0], ns[5:0], nm[0], b[0], n[2:0]};
    endfunction

    function automatic logic [28:0] dut_out();
        dut_out = {o_ivlCurrRange, o_ivlOffset, o_pStateIdx,
                   o_valMps, o_binVal, o_output_len};
    endfunction

    task automatic drive(input int rng, input int off, input int st,
                         input int mps, input logic [5:0] rb);
        i_ivlCurrRange = rng[8:0];
        i_ivlOffset    = off[8:0];
        i_pStateIdx    = st[5:0];
        i_valMps       = mps[0];
        i_rbsp_in      = rb;
    endtask

    task automatic directed(input string tag, input int rng, input int off,
                            input int st, input int mps, input logic [5:0] rb,
                            input int e_bin, input int e_st, input int e_mps,
                            input int e_rng, input int e_off, input int e_len);
        @(negedge clk);
        drive(rng, off, st, mps, rb);
        #1;
        check_eq({tag, ".bin"},   32'(o_binVal),       32'(e_bin));
        check_eq({tag, ".state"}, 32'(o_pStateIdx),    32'(e_st));
        check_eq({tag, ".mps"},   32'(o_valMps),       32'(e_mps));
        check_eq({tag, ".range"}, 32'(o_ivlCurrRange), 32'(e_rng));
        check_eq({tag, ".off"},   32'(o_ivlOffset),    32'(e_off));
        check_eq({tag, ".len"},   32'(o_output_len),   32'(e_len));
    endtask

    initial begin
        logic [28:0] held;
        int rng, rm, off;
        logic [5:0] rb;
        rst = 1'b1;
        drive(0, 0, 0, 0, 6'd0);

        // Outputs reflect inputs even while reset is held.
        directed("rst_mps", 510, 0, 0, 0, 6'b000000, 0, 1, 0, 270, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        directed("mps_norenorm", 510, 0, 0, 0, 6'b000000, 0, 1, 0, 270, 0, 0);
        directed("lps_flip", 510, 300, 0, 0, 6'b100000, 1, 0, 1, 480, 61, 1);
        directed("mps_sat", 256, 0, 62, 1, 6'b000000, 1, 62, 1, 500, 0, 1);
        directed("max_renorm", 256, 250, 62, 0, 6'b101011,
                 1, 38, 0, 384, 43, 6);
        directed("mid_lps", 400, 290, 10, 1, 6'b110000, 0, 8, 1, 492, 55, 2);
        directed("st63_as_62", 256, 250, 63, 0, 6'b101011,
                 1, 38, 0, 384, 43, 6);

        // Reset toggled mid-operation must leave outputs untouched.
        @(negedge clk);
        drive(400, 290, 10, 1, 6'b110000);
        #1;
        held = dut_out();
        check_eq("rst_mid_before", 32'(held), 32'(model(400, 290, 10, 1, 6'b110000)));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_assert", 32'(dut_out()), 32'(held));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_mid_release", 32'(dut_out()), 32'(held));

        for (int s = 0; s < 64; s++) begin
            for (int q = 0; q < 4; q++) begin
                rng = 256 + q * 64 + int'($urandom_range(62, 0));
                rm  = rng - lps_tab[(s == 63) ? 62 : s][q];
                for (int path = 0; path < 2; path++) begin
                    off = (path == 0) ? int'($urandom_range(rm - 1, 0)) : rng - 1;
                    rb  = 6'($urandom);
                    @(negedge clk);
                    rst = ~rst;
                    drive(rng, off, s, (s + q) & 1, rb);
                    #1;
                    check_eq($sformatf("sweep s%0d q%0d p%0d", s, q, path),
                             32'(dut_out()),
                             32'(model(rng, off, s, (s + q) & 1, rb)));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
